// File: rtl/vending_machine_multi.sv
// Multi-item vending machine: coin credit, per-item stock, greedy change return.
// Every output is registered, so each response follows its sampled input by one cycle.
module vending_machine_multi #(
  parameter int N_ITEMS    = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 10,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 100,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_VEC = {8'd25, 8'd15, 8'd10, 8'd5}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       coin_valid,
  input  logic [1:0]                 coin,
  input  logic                       sel_valid,
  input  logic [$clog2(N_ITEMS)-1:0] sel_idx,
  input  logic                       cancel,
  input  logic                       refill,
  output logic                       coin_accept,
  output logic                       coin_reject,
  output logic                       item_valid,
  output logic [$clog2(N_ITEMS)-1:0] item_idx,
  output logic                       change_valid,
  output logic [1:0]                 change_coin,
  output logic [CREDIT_W-1:0]        credit,
  output logic [N_ITEMS-1:0]         stock_empty,
  output logic                       err_sold_out,
  output logic                       err_insufficient,
  output logic                       busy
);
  localparam int IDX_W = $clog2(N_ITEMS);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [STOCK_W-1:0]  stock_reg  [N_ITEMS];
  logic [STOCK_W-1:0]  stock_next [N_ITEMS];
  logic [CREDIT_W-1:0] price      [N_ITEMS];
  logic [N_ITEMS-1:0]  empty_next;

  logic             coin_accept_next, coin_reject_next, item_valid_next, change_valid_next;
  logic             err_sold_out_next, err_insufficient_next, busy_next;
  logic [IDX_W-1:0] item_idx_next;
  logic [1:0]       change_coin_next;

  logic [CREDIT_W-1:0] coin_value, change_value, sel_price;
  logic [CREDIT_W:0]   coin_sum;
  logic [1:0]          change_code;
  logic [IDX_W-1:0]    sel_safe;
  logic [STOCK_W-1:0]  sel_stock;
  logic in_wait, sel_in_range, coin_ok;
  logic do_cancel, do_sel, do_coin, coin_take, sel_vend, sel_sold, sel_short, sel_idle;
  logic do_refill, chg_issue;

  genvar gi;
  generate
    for (gi = 0; gi < N_ITEMS; gi++) begin : g_item
      assign price[gi] = PRICE_VEC[gi*CREDIT_W +: CREDIT_W];
      assign stock_next[gi] = do_refill ? STOCK_W'(INIT_STOCK) :
                              (sel_vend && sel_safe == IDX_W'(gi)) ? stock_reg[gi] - STOCK_W'(1) :
                              stock_reg[gi];
      assign empty_next[gi] = (stock_next[gi] == '0);
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) stock_reg[gi] <= STOCK_W'(INIT_STOCK);
        else        stock_reg[gi] <= stock_next[gi];
      end
    end
  endgenerate

  always_comb begin
    case (coin)
      2'b01:   coin_value = CREDIT_W'(5);
      2'b10:   coin_value = CREDIT_W'(10);
      2'b11:   coin_value = CREDIT_W'(20);
      default: coin_value = '0;
    endcase
  end

  assign in_wait      = (state_reg == S_IDLE) || (state_reg == S_CREDIT);
  assign coin_sum     = {1'b0, credit_reg} + {1'b0, coin_value};
  assign coin_ok      = (coin != 2'b00) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign sel_in_range = (32'(sel_idx) < N_ITEMS);
  assign sel_safe     = sel_in_range ? sel_idx : '0;
  assign sel_price    = price[sel_safe];
  assign sel_stock    = stock_reg[sel_safe];

  // Priority cancel > selection > coin; cancel with no credit is not an event at all.
  assign do_cancel = (state_reg == S_CREDIT) && cancel;
  assign do_sel    = in_wait && sel_valid && !do_cancel;
  assign do_coin   = in_wait && coin_valid && !do_cancel && !do_sel;
  assign coin_take = do_coin && coin_ok;
  assign sel_idle  = do_sel && (state_reg == S_IDLE);
  assign sel_sold  = do_sel && (state_reg == S_CREDIT) && sel_in_range && (sel_stock == '0);
  assign sel_short = do_sel && (state_reg == S_CREDIT) && sel_in_range && (sel_stock != '0)
                     && (credit_reg < sel_price);
  assign sel_vend  = do_sel && (state_reg == S_CREDIT) && sel_in_range && (sel_stock != '0)
                     && (credit_reg >= sel_price);
  assign do_refill = (state_reg == S_IDLE) && refill;
  assign chg_issue = (state_reg == S_CHANGE) && (credit_reg != '0);

  assign change_value = (credit_reg >= CREDIT_W'(20)) ? CREDIT_W'(20) :
                        (credit_reg >= CREDIT_W'(10)) ? CREDIT_W'(10) : CREDIT_W'(5);
  assign change_code  = (credit_reg >= CREDIT_W'(20)) ? 2'b11 :
                        (credit_reg >= CREDIT_W'(10)) ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      credit_reg       <= '0;
      coin_accept      <= 1'b0;
      coin_reject      <= 1'b0;
      item_valid       <= 1'b0;
      item_idx         <= '0;
      change_valid     <= 1'b0;
      change_coin      <= 2'b00;
      err_sold_out     <= 1'b0;
      err_insufficient <= 1'b0;
      busy             <= 1'b0;
      stock_empty      <= {N_ITEMS{INIT_STOCK == 0}};
    end else begin
      state_reg        <= state_next;
      credit_reg       <= credit_next;
      coin_accept      <= coin_accept_next;
      coin_reject      <= coin_reject_next;
      item_valid       <= item_valid_next;
      item_idx         <= item_idx_next;
      change_valid     <= change_valid_next;
      change_coin      <= change_coin_next;
      err_sold_out     <= err_sold_out_next;
      err_insufficient <= err_insufficient_next;
      busy             <= busy_next;
      stock_empty      <= empty_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    case (state_reg)
      S_IDLE: begin
        if (coin_take) begin
          credit_next = coin_sum[CREDIT_W-1:0];
          state_next  = S_CREDIT;
        end
      end
      S_CREDIT: begin
        if (do_cancel) begin
          state_next = S_CHANGE;
        end else if (sel_vend) begin
          credit_next = credit_reg - sel_price;
          state_next  = S_VEND;
        end else if (coin_take) begin
          credit_next = coin_sum[CREDIT_W-1:0];
        end
      end
      S_VEND: state_next = (credit_reg != '0) ? S_CHANGE : S_IDLE;
      default: begin
        // One extra CHANGE cycle with zero credit precedes the return to IDLE.
        if (credit_reg == '0) state_next = S_IDLE;
        else                  credit_next = credit_reg - change_value;
      end
    endcase
  end

  always_comb begin
    coin_accept_next      = coin_take;
    coin_reject_next      = coin_valid && !coin_take;
    item_valid_next       = sel_vend;
    item_idx_next         = sel_vend ? sel_idx : '0;
    change_valid_next     = chg_issue;
    change_coin_next      = chg_issue ? change_code : 2'b00;
    err_sold_out_next     = sel_sold;
    err_insufficient_next = sel_short || sel_idle;
    busy_next             = (state_next == S_VEND) || (state_next == S_CHANGE);
  end

  assign credit = credit_reg;
endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios plus random traffic, all
// checked each cycle against a credit/stock/change-queue model of the machine.
module tb_vending_machine_multi;
  localparam int N    = 4;
  localparam int INIT = 10;
  localparam int MAXC = 100;
  int price_tab [N] = '{5, 10, 15, 25};

  logic clk = 1'b0, reset = 1'b0;
  logic coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0, refill = 1'b0;
  logic [1:0] coin = 2'b00, sel_idx = 2'b00;
  logic coin_accept, coin_reject, item_valid, change_valid, err_sold_out, err_insufficient, busy;
  logic [1:0] item_idx, change_coin;
  logic [7:0] credit;
  logic [3:0] stock_empty;

  vending_machine_multi dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .refill(refill),
    .coin_accept(coin_accept), .coin_reject(coin_reject), .item_valid(item_valid),
    .item_idx(item_idx), .change_valid(change_valid), .change_coin(change_coin),
    .credit(credit), .stock_empty(stock_empty), .err_sold_out(err_sold_out),
    .err_insufficient(err_insufficient), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc_n = 0;
  int m_credit, m_stock [N];
  int sched [$];  // per-cycle change coin still owed while busy (0 = no coin that cycle)
  int e_acc, e_rej, e_item, e_idx, e_chg, e_coin, e_sold, e_ins, e_busy;
  int chg_log [$], chg_cyc [$];
  int n_item = 0, last_item = 0, n_acc = 0, n_rej = 0, n_sold = 0, n_ins = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc_n, act, exp);
    end
  endtask

  function automatic int coin_val(input logic [1:0] c);
    return (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : (c == 2'b11) ? 20 : 0;
  endfunction

  function automatic int code_of(input int v);
    return (v == 20) ? 3 : (v == 10) ? 2 : 1;
  endfunction

  task automatic queue_change(input int c);
    int r;
    r = c;
    while (r > 0) begin
      if (r >= 20) begin sched.push_back(20); r -= 20; end
      else if (r >= 10) begin sched.push_back(10); r -= 10; end
      else begin sched.push_back(5); r -= 5; end
    end
    sched.push_back(0);
  endtask

  task automatic model_reset();
    m_credit = 0;
    sched.delete();
    for (int i = 0; i < N; i++) m_stock[i] = INIT;
    e_acc = 0; e_rej = 0; e_item = 0; e_idx = 0; e_chg = 0; e_coin = 0;
    e_sold = 0; e_ins = 0; e_busy = 0;
  endtask

  task automatic model_step();
    int v;
    bit was_idle, cancel_eff;
    e_acc = 0; e_rej = 0; e_item = 0; e_idx = 0; e_chg = 0; e_coin = 0; e_sold = 0; e_ins = 0;
    if (sched.size() > 0) begin
      v = sched.pop_front();
      if (v != 0) begin e_chg = 1; e_coin = code_of(v); m_credit -= v; end
      e_rej = int'(coin_valid);
    end else begin
      was_idle = (m_credit == 0);
      cancel_eff = cancel && !was_idle;
      if (cancel_eff) begin
        queue_change(m_credit);
      end else if (sel_valid) begin
        if (was_idle) e_ins = 1;
        else if (int'(sel_idx) < N) begin
          if (m_stock[sel_idx] == 0) e_sold = 1;
          else if (m_credit < price_tab[sel_idx]) e_ins = 1;
          else begin
            e_item = 1; e_idx = int'(sel_idx);
            m_stock[sel_idx]--;
            m_credit -= price_tab[sel_idx];
            sched.push_back(0);
            if (m_credit > 0) queue_change(m_credit);
          end
        end
      end
      if (coin_valid) begin
        if (!cancel_eff && !sel_valid && coin != 2'b00 && m_credit + coin_val(coin) <= MAXC) begin
          e_acc = 1; m_credit += coin_val(coin);
        end else e_rej = 1;
      end
      if (refill && was_idle) for (int i = 0; i < N; i++) m_stock[i] = INIT;
    end
    e_busy = (sched.size() > 0) ? 1 : 0;
  endtask

  // Compare process: every post-reset cycle, DUT outputs against the model.
  initial begin
    int exp_empty;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        exp_empty = 0;
        for (int i = 0; i < N; i++) if (m_stock[i] == 0) exp_empty |= (1 << i);
        check("coin_accept", int'(coin_accept), e_acc);
        check("coin_reject", int'(coin_reject), e_rej);
        check("item_valid", int'(item_valid), e_item);
        if (e_item != 0) check("item_idx", int'(item_idx), e_idx);
        check("change_valid", int'(change_valid), e_chg);
        if (e_chg != 0) check("change_coin", int'(change_coin), e_coin);
        check("credit", int'(credit), m_credit);
        check("stock_empty", int'(stock_empty), exp_empty);
        check("err_sold_out", int'(err_sold_out), e_sold);
        check("err_insufficient", int'(err_insufficient), e_ins);
        check("busy", int'(busy), e_busy);
        if (item_valid) begin n_item++; last_item = int'(item_idx); end
        if (change_valid) begin chg_log.push_back(coin_val(change_coin)); chg_cyc.push_back(cyc_n); end
        if (coin_accept) n_acc++;
        if (coin_reject) n_rej++;
        if (err_sold_out) n_sold++;
        if (err_insufficient) n_ins++;
      end
    end
  end

  task automatic cyc(input logic cv, input logic [1:0] cn, input logic sv, input logic [1:0] si,
                     input logic cc, input logic rf);
    coin_valid = cv; coin = cn; sel_valid = sv; sel_idx = si; cancel = cc; refill = rf;
    @(posedge clk);
    model_step();
    cyc_n++;
    @(negedge clk);
    #1;
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; refill = 1'b0;
  endtask

  task automatic put_coin(input logic [1:0] c); cyc(1'b1, c, 1'b0, 2'd0, 1'b0, 1'b0); endtask
  task automatic select(input logic [1:0] i);   cyc(1'b0, 2'd0, 1'b1, i, 1'b0, 1'b0); endtask
  task automatic do_cancel();                   cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0); endtask
  task automatic do_idle();                     cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0); endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin do_idle(); n++; end
    check("wait_idle timeout", int'(busy), 0);
  endtask

  task automatic clear_logs();
    chg_log.delete(); chg_cyc.delete();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without waiting for a clock edge.
  task automatic mid_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check("reset change_valid", int'(change_valid), 0);
    check("reset credit", int'(credit), 0);
    check("reset busy", int'(busy), 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int a0, r0, i0, s0, q0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst coin_accept", int'(coin_accept), 0);
    check("rst coin_reject", int'(coin_reject), 0);
    check("rst item_valid", int'(item_valid), 0);
    check("rst item_idx", int'(item_idx), 0);
    check("rst change_valid", int'(change_valid), 0);
    check("rst change_coin", int'(change_coin), 0);
    check("rst credit", int'(credit), 0);
    check("rst stock_empty", int'(stock_empty), 0);
    check("rst errors", int'(err_sold_out) + int'(err_insufficient), 0);
    check("rst busy", int'(busy), 0);
    reset = 1'b1;

    // 10 + 10, buy item1 (10): one 10 coin back, stock[1] drops to 9.
    clear_logs(); i0 = n_item;
    put_coin(2'b10); put_coin(2'b10); select(2'd1); wait_idle();
    check("r46 items", n_item - i0, 1);
    check("r46 item_idx", last_item, 1);
    check("r46 change count", chg_log.size(), 1);
    if (chg_log.size() > 0) check("r46 change coin", chg_log[0], 10);
    check("r46 credit", int'(credit), 0);
    check("r46 model stock1", m_stock[1], 9);

    // Credit ceiling: five 20s reach 100, a further 5 is rejected.
    a0 = n_acc; r0 = n_rej;
    repeat (4) put_coin(2'b11);
    check("r47 credit80", int'(credit), 80);
    put_coin(2'b11);
    check("r47 credit100", int'(credit), 100);
    check("r47 accepts", n_acc - a0, 5);
    put_coin(2'b01);
    check("r47 reject", n_rej - r0, 1);
    check("r47 credit held", int'(credit), 100);
    clear_logs(); do_cancel(); wait_idle();
    check("r47 refund coins", chg_log.size(), 5);

    // 5 is not enough for item3 (25); cancel refunds the 5.
    q0 = n_ins;
    put_coin(2'b01); select(2'd3);
    check("r48 insufficient", n_ins - q0, 1);
    check("r48 credit", int'(credit), 5);
    clear_logs(); do_cancel(); wait_idle();
    check("r48 change count", chg_log.size(), 1);
    if (chg_log.size() > 0) check("r48 change coin", chg_log[0], 5);

    // Drain item0, then sold-out, then refill from IDLE.
    for (int k = 0; k < 10; k++) begin put_coin(2'b01); select(2'd0); wait_idle(); end
    check("r49 empty0", int'(stock_empty[0]), 1);
    s0 = n_sold;
    put_coin(2'b01); select(2'd0);
    check("r49 sold_out", n_sold - s0, 1);
    check("r49 credit kept", int'(credit), 5);
    do_cancel(); wait_idle();
    cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    check("r49 refilled", int'(stock_empty[0]), 0);
    check("r49 model stock0", m_stock[0], 10);

    // 45 credit, item2 (15): change 20 then 10 back to back; coin during CHANGE bounces.
    put_coin(2'b11); put_coin(2'b11); put_coin(2'b01);
    clear_logs(); r0 = n_rej;
    select(2'd2);
    check("r50 credit after vend", int'(credit), 30);
    do_idle();
    put_coin(2'b10);
    check("r50 busy reject", n_rej - r0, 1);
    wait_idle();
    check("r50 change count", chg_log.size(), 2);
    if (chg_log.size() == 2) begin
      check("r50 first coin", chg_log[0], 20);
      check("r50 second coin", chg_log[1], 10);
      check("r50 consecutive", chg_cyc[1] - chg_cyc[0], 1);
    end

    // Cancel beats a same-cycle selection.
    put_coin(2'b10);
    clear_logs(); i0 = n_item;
    cyc(1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0);
    wait_idle();
    check("r51 no item", n_item - i0, 0);
    check("r51 change count", chg_log.size(), 1);
    if (chg_log.size() > 0) check("r51 change coin", chg_log[0], 10);

    // Reset while refunding 30.
    put_coin(2'b11); put_coin(2'b10); do_cancel();
    check("r52 busy", int'(busy), 1);
    check("r52 credit30", int'(credit), 30);
    mid_reset();
    do_idle();
    check("r52 no late change", int'(change_valid), 0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) mid_reset();
      cyc($urandom_range(0, 99) < 35, 2'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 12, 2'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 Parameter N_ITEMS, default 4: number of selectable items, 2..16.
REQ-002 Parameter STOCK_W, default 4: width of each per-item stock counter.
REQ-003 Parameter INIT_STOCK, default 10: stock loaded per item at reset and on refill; must be less than 2**STOCK_W.
REQ-004 Parameter CREDIT_W, default 8: width of credit and price values, in rupees.
REQ-005 Parameter MAX_CREDIT, default 100: credit ceiling in rupees; must be a multiple of 5.
REQ-006 Parameter PRICE_VEC, N_ITEMS*CREDIT_W bits, default {25,15,10,5} (item3..item0): per-item price; each entry nonzero and a multiple of 5.
REQ-007 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-008 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port coin_valid, input, 1 bit: coin present this cycle.
REQ-010 Port coin, input, 2 bits: 01=5, 10=10, 11=20; 00 is illegal and is rejected.
REQ-011 Port sel_valid, input, 1 bit: selection request this cycle.
REQ-012 Port sel_idx, input, $clog2(N_ITEMS) bits: index of the selected item.
REQ-013 Port cancel, input, 1 bit: return all credit.
REQ-014 Port refill, input, 1 bit: service request to restore all stock.
REQ-015 Port coin_accept, output, 1 bit: one-cycle pulse, coin credited.
REQ-016 Port coin_reject, output, 1 bit: one-cycle pulse, coin returned.
REQ-017 Port item_valid, output, 1 bit: one-cycle dispense pulse.
REQ-018 Port item_idx, output, $clog2(N_ITEMS) bits: index of the dispensed item; valid while item_valid is high.
REQ-019 Port change_valid, output, 1 bit: one change coin is output this cycle.
REQ-020 Port change_coin, output, 2 bits: denomination of the change coin, same encoding as coin.
REQ-021 Port credit, output, CREDIT_W bits: current credit.
REQ-022 Port stock_empty, output, N_ITEMS bits: bit i is high when stock[i]==0.
REQ-023 Port err_sold_out, output, 1 bit: one-cycle pulse.
REQ-024 Port err_insufficient, output, 1 bit: one-cycle pulse.
REQ-025 Port busy, output, 1 bit: high in VEND and CHANGE.

Function
REQ-026 States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE; every output is registered, and each response appears one cycle after its input is sampled.
REQ-027 Coin handling in IDLE or CREDIT: if coin!=00 and credit+value<=MAX_CREDIT, add value to credit, pulse coin_accept, and go to CREDIT; otherwise pulse coin_reject and leave credit unchanged.
REQ-028 Selection in CREDIT with sel_idx>=N_ITEMS: ignored.
REQ-029 Selection in CREDIT with stock[sel_idx]==0: pulse err_sold_out, retain credit, stay in CREDIT.
REQ-030 Selection in CREDIT with credit<price: pulse err_insufficient, retain credit, stay in CREDIT.
REQ-031 Valid selection in CREDIT: enter VEND; in that cycle, pulse item_valid with item_idx=sel_idx, decrement stock by 1, and subtract price from credit.
REQ-032 From VEND: go to CHANGE if the remaining credit is greater than 0, else to IDLE.
REQ-033 Selection in IDLE: no dispense; pulse err_insufficient.
REQ-034 Cancel in CREDIT: go to CHANGE without dispensing.
REQ-035 Cancel in IDLE: ignored.
REQ-036 CHANGE state: output one coin per cycle, greedy largest first (20, then 10, then 5), each with change_valid high; decrement credit by the coin value.
REQ-037 CHANGE exit: go to IDLE in the cycle after credit reaches 0.
REQ-038 Same-cycle priority: cancel > sel_valid > coin_valid; any coin arriving with a higher-priority event is rejected.
REQ-039 In VEND or CHANGE: coin_valid always produces coin_reject; sel_valid, cancel and refill are ignored.
REQ-040 Refill: acts only in IDLE; loads INIT_STOCK into every stock counter next cycle; ignored in any other state.
REQ-041 Stock counters never wrap below 0; credit never exceeds MAX_CREDIT and never goes negative.
REQ-042 coin_valid with coin=00 in IDLE or CREDIT: pulse coin_reject.

Reset
REQ-043 While reset is low: state=IDLE, credit=0, every stock counter=INIT_STOCK, and all pulse outputs, item_idx, change_coin and busy are 0.
REQ-044 Reset asserted during CHANGE or VEND: abort immediately; the remaining credit is discarded and no further change coin is issued.
REQ-045 After reset deasserts: the first input is sampled on the next rising clk edge.

Verification
REQ-046 Coins 10 then 10, select item1 (price 10) -> item_valid with item_idx=1; change one coin 10; credit 0; stock[1]=9.
REQ-047 Coin 20, then coin 20 three times, then coin 20 once more -> four coin_accept pulses with credit=80, then the fifth coin 20 is accepted (credit=100); a further coin 5 -> coin_reject, credit stays 100.
REQ-048 Coin 5, select item3 (price 25) -> err_insufficient, credit stays 5; cancel -> change one coin 5, then IDLE.
REQ-049 Ten vends of item0 (coin 5 each) -> stock_empty[0]=1; an eleventh attempt -> err_sold_out, credit 5 retained; refill after cancel -> stock[0]=10.
REQ-050 Coin 20 + coin 20 + coin 5 (credit 45), select item2 (price 15) -> change coins 20, 10 in consecutive cycles; a coin inserted during CHANGE -> coin_reject.
REQ-051 Same-cycle cancel and sel_valid with credit 10 -> no item_valid; change coin 10.
REQ-052 reset low during CHANGE with credit 30 -> change_valid=0 immediately; credit=0; state IDLE.
